mips_multicycle_ctrl: RTL and testbench

Main control FSM that sequences the 32-bit MIPS datapath as a multicycle machine. It drives the datapath control lines (RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp) plus PC/IR/address-mux strobes, one state per datapath step. It decodes the opcode returned by the datapath and stalls on a shared-memory ready handshake. It sits beside Datapath_32 at the CPU top level.

---
 rtl/mips_multicycle_ctrl_if.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS control FSM (master) and Datapath_32 (slave).
// Carries the decoded opcode and memory handshake in, and the datapath strobes out.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       RegDst;
  logic       Jump;
  logic       Branch;
  logic       MemRead;
  logic       MemtoReg;
  logic       MemWrite;
  logic       ALUSrc;
  logic       RegWrite;
  logic [1:0] ALUOp;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic [3:0] state_o;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
    output ALUOp, PCWrite, IRWrite, IorD, state_o, instr_done, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
    input  ALUOp, PCWrite, IRWrite, IorD, state_o, instr_done, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: one state per datapath step, stalls on mem_ready.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal) instead of executing as NOP.
module mips_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       instr_done;
  } ctrl_t;

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_s;

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_known = 1'b1;
      default:                                        op_known = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; opcode is only trusted from DECODE onward
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        case (bus.opcode)
          OP_LW:   state_d = S_MEM_READ;
          OP_SW:   state_d = S_MEM_WRITE;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        if (bus.mem_ready) state_d = S_MEM_WB;
        else               state_d = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               state_d = S_MEM_WRITE;
      end
      S_EXECUTE: state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; gated by rst_n so a pending write is dropped the moment reset asserts
  always_comb begin
    ctrl_s = '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ctrl_s.mem_read = 1'b1;
          ctrl_s.ir_write = bus.mem_ready;
          ctrl_s.pc_write = bus.mem_ready;
        end
        S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          ctrl_s.instr_done = 1'b0;
`else
          ctrl_s.instr_done = ~op_known(bus.opcode);
`endif
        end
        S_MEM_ADDR: begin
          ctrl_s.alu_src = 1'b1;
          ctrl_s.alu_op  = 2'b00;
        end
        S_MEM_READ: begin
          ctrl_s.mem_read = 1'b1;
          ctrl_s.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.mem_to_reg = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl_s.mem_write  = 1'b1;
          ctrl_s.i_or_d     = 1'b1;
          ctrl_s.instr_done = bus.mem_ready;
        end
        S_EXECUTE: begin
          ctrl_s.alu_op = 2'b10;
        end
        S_R_WB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl_s.branch     = 1'b1;
          ctrl_s.alu_op     = 2'b01;
          ctrl_s.instr_done = 1'b1;
        end
        S_JUMP: begin
          ctrl_s.jump       = 1'b1;
          ctrl_s.pc_write   = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_ADDI_EX: begin
          ctrl_s.alu_src = 1'b1;
          ctrl_s.alu_op  = 2'b00;
        end
        S_ADDI_WB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        default: ctrl_s = '0;
      endcase
    end else begin
      ctrl_s = '0;
    end
  end

  assign bus.RegDst     = ctrl_s.reg_dst;
  assign bus.Jump       = ctrl_s.jump;
  assign bus.Branch     = ctrl_s.branch;
  assign bus.MemRead    = ctrl_s.mem_read;
  assign bus.MemtoReg   = ctrl_s.mem_to_reg;
  assign bus.MemWrite   = ctrl_s.mem_write;
  assign bus.ALUSrc     = ctrl_s.alu_src;
  assign bus.RegWrite   = ctrl_s.reg_write;
  assign bus.ALUOp      = ctrl_s.alu_op;
  assign bus.PCWrite    = ctrl_s.pc_write;
  assign bus.IRWrite    = ctrl_s.ir_write;
  assign bus.IorD       = ctrl_s.i_or_d;
  assign bus.instr_done = ctrl_s.instr_done;
  assign bus.state_o    = rst_n ? 4'(state_q) : 4'd0;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_d;

  // Sticky flag set on the DECODE cycle that sends the FSM into TRAP
  always_comb begin
    if (state_q == S_DECODE && !op_known(bus.opcode)) illegal_d = 1'b1;
    else                                                illegal_d = illegal_q;
  end

  // Illegal flag register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus random instruction
// streams checked against an instruction-level trace model built from the step table.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Observed/expected vector = {state_o, 14 flag bits below}
  localparam logic [13:0] RD   = 14'h2000;
  localparam logic [13:0] JP   = 14'h1000;
  localparam logic [13:0] BR   = 14'h0800;
  localparam logic [13:0] MR   = 14'h0400;
  localparam logic [13:0] M2R  = 14'h0200;
  localparam logic [13:0] MW   = 14'h0100;
  localparam logic [13:0] AS   = 14'h0080;
  localparam logic [13:0] RW   = 14'h0040;
  localparam logic [13:0] AF   = 14'h0020;
  localparam logic [13:0] ASUB = 14'h0010;
  localparam logic [13:0] PCW  = 14'h0008;
  localparam logic [13:0] IRW  = 14'h0004;
  localparam logic [13:0] IORD = 14'h0002;
  localparam logic [13:0] DONE = 14'h0001;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus_if ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [17:0] exp;
    logic        mr;
    logic [5:0]  op;
    int          lat;
  } step_t;

  step_t q[$];

  function automatic logic [17:0] ev(input logic [3:0] st, input logic [13:0] f);
    return {st, f};
  endfunction

  function automatic bit known(input logic [5:0] op);
    return (op == OP_RTYPE || op == OP_LW || op == OP_SW ||
            op == OP_BEQ || op == OP_J || op == OP_ADDI);
  endfunction

  // Instruction latency with no stalls, straight from the published table
  function automatic int spec_latency(input logic [5:0] op);
    case (op)
      OP_RTYPE: return 4;
      OP_LW:    return 5;
      OP_SW:    return 4;
      OP_BEQ:   return 3;
      OP_J:     return 3;
      OP_ADDI:  return 4;
      default:  return 2;
    endcase
  endfunction

  task automatic add_step(input logic [17:0] e, input logic mr, input logic [5:0] op, input int lat);
    step_t s;
    s.exp = e; s.mr = mr; s.op = op; s.lat = lat;
    q.push_back(s);
  endtask

  // Reference model: expands one instruction into its expected per-cycle trace
  task automatic add_instr(input logic [5:0] op, input int fstall, input int mstall);
    int lat;
    lat = spec_latency(op) + fstall + ((op == OP_LW || op == OP_SW) ? mstall : 0);
    for (int i = 0; i < fstall; i++) add_step(ev(4'd0, MR), 1'b0, 6'($urandom), lat);
    add_step(ev(4'd0, MR | IRW | PCW), 1'b1, 6'($urandom), lat);
    if (!known(op)) begin
      add_step(ev(4'd1, DONE), 1'($urandom), op, lat);
    end else begin
      add_step(ev(4'd1, 14'h0), 1'($urandom), op, lat);
      case (op)
        OP_RTYPE: begin
          add_step(ev(4'd6, AF), 1'($urandom), op, lat);
          add_step(ev(4'd7, RW | RD | DONE), 1'($urandom), op, lat);
        end
        OP_LW: begin
          add_step(ev(4'd2, AS), 1'($urandom), op, lat);
          for (int i = 0; i < mstall; i++) add_step(ev(4'd3, MR | IORD), 1'b0, op, lat);
          add_step(ev(4'd3, MR | IORD), 1'b1, op, lat);
          add_step(ev(4'd4, RW | M2R | DONE), 1'($urandom), op, lat);
        end
        OP_SW: begin
          add_step(ev(4'd2, AS), 1'($urandom), op, lat);
          for (int i = 0; i < mstall; i++) add_step(ev(4'd5, MW | IORD), 1'b0, op, lat);
          add_step(ev(4'd5, MW | IORD | DONE), 1'b1, op, lat);
        end
        OP_BEQ:  add_step(ev(4'd8, BR | ASUB | DONE), 1'($urandom), op, lat);
        OP_J:    add_step(ev(4'd9, JP | PCW | DONE), 1'($urandom), op, lat);
        default: begin
          add_step(ev(4'd10, AS), 1'($urandom), op, lat);
          add_step(ev(4'd11, RW | DONE), 1'($urandom), op, lat);
        end
      endcase
    end
  endtask

  // Drive inputs just after a rising edge, sample at the falling edge, return at posedge+1
  task automatic cycle(input logic mr, input logic [5:0] op, output logic [17:0] obs, output logic ill);
    bus_if.mem_ready = mr;
    bus_if.opcode    = op;
    @(negedge clk);
    obs = {bus_if.state_o, bus_if.RegDst, bus_if.Jump, bus_if.Branch, bus_if.MemRead,
           bus_if.MemtoReg, bus_if.MemWrite, bus_if.ALUSrc, bus_if.RegWrite, bus_if.ALUOp,
           bus_if.PCWrite, bus_if.IRWrite, bus_if.IorD, bus_if.instr_done};
    ill = bus_if.illegal;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    logic        ill;
    rst_n = 1'b0;
    bus_if.opcode = OP_LW;
    bus_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, OP_LW, obs, ill);
      n_checks++;
      if (obs !== 18'h0 || ill !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h ill %b want 00000 ill 0", i, obs, ill);
      end
    end
    rst_n = 1'b1;
    cycle(1'b0, OP_LW, obs, ill);
    n_checks++;
    if (obs !== ev(4'd0, MR)) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs, ev(4'd0, MR));
    end
  endtask

  task automatic test_rtype();
    step_t s;
    logic [17:0] obs;
    logic        ill;
    add_instr(OP_RTYPE, 0, 0);
    for (int i = 0; q.size() > 0; i++) begin
      s = q.pop_front();
      cycle(s.mr, s.op, obs, ill);
      n_checks++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL rtype step %0d: got %h want %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_lw_stall();
    step_t s;
    logic [17:0] obs;
    logic        ill;
    int          n;
    n = 0;
    add_instr(OP_LW, 0, 2);
    while (q.size() > 0) begin
      s = q.pop_front();
      cycle(s.mr, s.op, obs, ill);
      n++;
      n_checks++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL lw_stall step %0d: got %h want %h", n, obs, s.exp);
      end
      if (obs[0]) begin
        n_checks++;
        if (n !== 7) begin
          n_fail++;
          $display("FAIL lw_stall_len: got %0d want 7", n);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    logic [17:0] obs;
    logic        ill;
    int          mw_cnt, idx;
    int          dones[$];
    mw_cnt = 0;
    idx = 0;
    add_instr(OP_SW, 0, 0);
    add_instr(OP_BEQ, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front();
      cycle(s.mr, s.op, obs, ill);
      n_checks++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL b2b step %0d: got %h want %h", idx, obs, s.exp);
      end
      if (obs[8]) mw_cnt++;
      if (obs[0]) dones.push_back(idx);
      idx++;
    end
    n_checks++;
    if (mw_cnt !== 1) begin
      n_fail++;
      $display("FAIL b2b_memwrite_cycles: got %0d want 1", mw_cnt);
    end
    n_checks++;
    if (dones.size() !== 2 || (dones[1] - dones[0]) !== 3) begin
      n_fail++;
      $display("FAIL b2b_done_gap: got %0d pulses gap %0d want 2 pulses gap 3",
               dones.size(), (dones.size() == 2) ? dones[1] - dones[0] : -1);
    end
  endtask

  task automatic test_reset_mid_write();
    step_t s;
    logic [17:0] obs;
    logic        ill;
    bit          hit;
    hit = 1'b0;
    bus_if.opcode = OP_SW;
    for (int k = 0; k < 8 && !hit; k++) begin
      cycle((k < 3) ? 1'b1 : 1'b0, OP_SW, obs, ill);
      if (obs[17:14] == 4'd5) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midwr_reach: state 5 not reached, last state %0d", obs[17:14]);
    end
    bus_if.mem_ready = 1'b0;
    #2;
    n_checks++;
    if (bus_if.MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL midwr_pre: MemWrite got %b want 1", bus_if.MemWrite);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.MemWrite !== 1'b0 || bus_if.state_o !== 4'd0) begin
      n_fail++;
      $display("FAIL midwr_async: MemWrite %b state %0d want 0 and 0", bus_if.MemWrite, bus_if.state_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_instr(OP_RTYPE, 1, 0);
    for (int i = 0; q.size() > 0; i++) begin
      s = q.pop_front();
      cycle(s.mr, s.op, obs, ill);
      n_checks++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL midwr_after step %0d: got %h want %h", i, obs, s.exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [17:0] obs;
    logic        ill;
`ifdef CTRL_ILLEGAL_TRAP_EN
    cycle(1'b1, 6'($urandom), obs, ill);
    n_checks++;
    if (obs !== ev(4'd0, MR | IRW | PCW)) begin
      n_fail++;
      $display("FAIL trap_fetch: got %h want %h", obs, ev(4'd0, MR | IRW | PCW));
    end
    cycle(1'($urandom), 6'b111111, obs, ill);
    n_checks++;
    if (obs !== ev(4'd1, 14'h0)) begin
      n_fail++;
      $display("FAIL trap_decode: got %h want %h", obs, ev(4'd1, 14'h0));
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom), 6'($urandom), obs, ill);
      n_checks++;
      if (obs !== ev(4'd12, 14'h0) || ill !== 1'b1) begin
        n_fail++;
        $display("FAIL trap_hold cyc %0d: got %h ill %b want %h ill 1", i, obs, ill, ev(4'd12, 14'h0));
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.illegal !== 1'b0 || bus_if.state_o !== 4'd0) begin
      n_fail++;
      $display("FAIL trap_clear: illegal %b state %0d want 0 and 0", bus_if.illegal, bus_if.state_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`else
    step_t s;
    add_instr(6'b111111, 0, 0);
    for (int i = 0; q.size() > 0; i++) begin
      s = q.pop_front();
      cycle(s.mr, s.op, obs, ill);
      n_checks++;
      if (obs !== s.exp || ill !== 1'b0) begin
        n_fail++;
        $display("FAIL nop step %0d: got %h ill %b want %h ill 0", i, obs, ill, s.exp);
      end
    end
`endif
  endtask

  task automatic test_random();
    step_t s;
    logic [17:0] obs;
    logic        ill;
    logic [5:0]  op;
    logic [5:0]  ops [6];
    int          cyc;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) op = ops[$urandom_range(0, 5)];
      else                           op = 6'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (!known(op)) op = ops[$urandom_range(0, 5)];
`endif
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    cyc = 0;
    for (int i = 0; q.size() > 0; i++) begin
      s = q.pop_front();
      cycle(s.mr, s.op, obs, ill);
      cyc++;
      n_checks++;
      if (obs !== s.exp || ill !== 1'b0) begin
        n_fail++;
        $display("FAIL random step %0d op %h: got %h ill %b want %h", i, s.op, obs, ill, s.exp);
      end
      if (obs[0]) begin
        n_checks++;
        if (cyc !== s.lat) begin
          n_fail++;
          $display("FAIL random_latency op %h: got %0d want %0d", s.op, cyc, s.lat);
        end
        cyc = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_back_to_back();
    test_reset_mid_write();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
